// File: rtl/motor_rodada.sv
// motor_rodada: round engine for the werewolf game.
//
// Holds roles and alive flags for N_JOG players, validates night actions (any number of wolves,
// one doctor), resolves the night kill, collects one replaceable vote per living player, tallies
// the votes one candidate per cycle with tie detection and evaluates both win conditions.
//
// Optional feature: define VIDENTE_EN to enable the seer role (role code 11). When it is
// undefined, role 11 behaves as a villager and revelado_lobo/revelado_valido are tied low.
//
// Ports:
//   clock, rst_global_n        system clock (rising edge), async active-low reset
//   novo_jogo, papeis          start/restart, role vector sampled on start (2 bits per player)
//   acao_valida/jogador/alvo   night action strobe, actor id, target id
//   fim_noite                  close the night and resolve the kill
//   voto_valido/eleitor/alvo   vote strobe, voter id, target id
//   fim_votacao                close voting and start the tally
//   vivos, n_vivos, n_lobos_vivos  alive flags and their popcounts
//   acao_aceita/acao_rejeitada     one-cycle outcome pulses for actions and votes
//   eliminado, eliminado_valido    eliminated player id and its one-cycle pulse
//   lobo_ganhou, aldeia_ganhou     sticky win flags
//   estado                         current FSM state
//   revelado_lobo, revelado_valido seer result pulse
module motor_rodada #(
  parameter int unsigned N_JOG = 8,
  parameter int unsigned IDW   = 4
) (
  input  logic               clock,
  input  logic               rst_global_n,
  input  logic               novo_jogo,
  input  logic [2*N_JOG-1:0] papeis,
  input  logic               acao_valida,
  input  logic [IDW-1:0]     acao_jogador,
  input  logic [IDW-1:0]     acao_alvo,
  input  logic               fim_noite,
  input  logic               voto_valido,
  input  logic [IDW-1:0]     voto_eleitor,
  input  logic [IDW-1:0]     voto_alvo,
  input  logic               fim_votacao,
  output logic [N_JOG-1:0]   vivos,
  output logic [IDW-1:0]     n_vivos,
  output logic [IDW-1:0]     n_lobos_vivos,
  output logic               acao_aceita,
  output logic               acao_rejeitada,
  output logic [IDW-1:0]     eliminado,
  output logic               eliminado_valido,
  output logic               lobo_ganhou,
  output logic               aldeia_ganhou,
  output logic [2:0]         estado,
  output logic               revelado_lobo,
  output logic               revelado_valido
);

  localparam logic [IDW-1:0] Skip        = '1;
  localparam logic [1:0]     PapelLobo   = 2'b01;
  localparam logic [1:0]     PapelMedico = 2'b10;
`ifdef VIDENTE_EN
  localparam logic [1:0]     PapelVidente = 2'b11;
`endif

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StNoite   = 3'd1,
    StResolve = 3'd2,
    StDia     = 3'd3,
    StApura   = 3'd4,
    StCheca   = 3'd5,
    StFim     = 3'd6
  } estado_e;

  // Out-of-range ids (including Skip) read as dead.
  function automatic logic id_vivo(input logic [N_JOG-1:0] v, input logic [IDW-1:0] id);
    logic r;
    r = 1'b0;
    for (int i = 0; i < N_JOG; i++) begin
      if (IDW'(i) == id) r = v[i];
    end
    return r;
  endfunction

  // Out-of-range ids read as villager.
  function automatic logic [1:0] papel_de(input logic [2*N_JOG-1:0] p, input logic [IDW-1:0] id);
    logic [1:0] r;
    r = 2'b00;
    for (int i = 0; i < N_JOG; i++) begin
      if (IDW'(i) == id) r = p[2*i +: 2];
    end
    return r;
  endfunction

  function automatic logic [N_JOG-1:0] mascara(input logic [IDW-1:0] id);
    logic [N_JOG-1:0] r;
    r = '0;
    for (int i = 0; i < N_JOG; i++) begin
      if (IDW'(i) == id) r[i] = 1'b1;
    end
    return r;
  endfunction

  estado_e                    state_q, state_d;
  logic [N_JOG-1:0]           vivos_q, vivos_d;
  logic [2*N_JOG-1:0]         papeis_q, papeis_d;
  logic [IDW-1:0]             atacado_q, atacado_d;
  logic [IDW-1:0]             protegido_q, protegido_d;
  logic [N_JOG-1:0][IDW-1:0]  votos_q, votos_d;
  logic                       fase_dia_q, fase_dia_d;   // phase that led into CHECA
  logic [IDW-1:0]             cand_q, cand_d;
  logic [IDW-1:0]             max_q, max_d;
  logic [IDW-1:0]             max_cand_q, max_cand_d;
  logic                       empate_q, empate_d;
  logic                       aceita_q, aceita_d;
  logic                       rejeitada_q, rejeitada_d;
  logic [IDW-1:0]             eliminado_q, eliminado_d;
  logic                       elim_valido_q, elim_valido_d;
  logic                       lobo_q, lobo_d;
  logic                       aldeia_q, aldeia_d;
`ifdef VIDENTE_EN
  logic                       rev_lobo_q, rev_lobo_d;
  logic                       rev_valido_q, rev_valido_d;
`endif

  logic [IDW-1:0] n_vivos_c, n_lobos_c, contagem;
  logic           ator_vivo, alvo_ok, alvo_lobo, eleitor_vivo, voto_ok;
  logic [1:0]     papel_ator;

  always_comb begin
    n_vivos_c = '0;
    n_lobos_c = '0;
    contagem  = '0;
    for (int i = 0; i < N_JOG; i++) begin
      n_vivos_c = n_vivos_c + IDW'(vivos_q[i]);
      n_lobos_c = n_lobos_c + IDW'(vivos_q[i] && (papeis_q[2*i +: 2] == PapelLobo));
      // Dead voters never count; Skip never matches a real candidate id.
      contagem  = contagem + IDW'(vivos_q[i] && (votos_q[i] == cand_q));
    end
  end

  always_comb begin
    ator_vivo    = id_vivo(vivos_q, acao_jogador);
    papel_ator   = papel_de(papeis_q, acao_jogador);
    alvo_ok      = (acao_alvo == Skip) || id_vivo(vivos_q, acao_alvo);
    alvo_lobo    = (papel_de(papeis_q, acao_alvo) == PapelLobo);
    eleitor_vivo = id_vivo(vivos_q, voto_eleitor);
    voto_ok      = (voto_alvo == Skip) || id_vivo(vivos_q, voto_alvo);
  end

  always_comb begin
    state_d       = state_q;
    vivos_d       = vivos_q;
    papeis_d      = papeis_q;
    atacado_d     = atacado_q;
    protegido_d   = protegido_q;
    votos_d       = votos_q;
    fase_dia_d    = fase_dia_q;
    cand_d        = cand_q;
    max_d         = max_q;
    max_cand_d    = max_cand_q;
    empate_d      = empate_q;
    aceita_d      = 1'b0;
    rejeitada_d   = 1'b0;
    eliminado_d   = eliminado_q;
    elim_valido_d = 1'b0;
    lobo_d        = lobo_q;
    aldeia_d      = aldeia_q;
`ifdef VIDENTE_EN
    rev_lobo_d    = 1'b0;
    rev_valido_d  = 1'b0;
`endif

    if (novo_jogo) begin
      vivos_d     = '1;
      papeis_d    = papeis;
      atacado_d   = Skip;
      protegido_d = Skip;
      votos_d     = '1;
      lobo_d      = 1'b0;
      aldeia_d    = 1'b0;
      state_d     = StNoite;
    end else begin
      case (state_q)
        StNoite: begin
          if (fim_noite) begin
            // Closing wins over a same-cycle action.
            rejeitada_d = acao_valida;
            state_d     = StResolve;
          end else if (acao_valida) begin
            rejeitada_d = 1'b1;
            if (ator_vivo && alvo_ok) begin
              case (papel_ator)
                PapelLobo: begin
                  if ((acao_alvo == Skip) || !alvo_lobo) begin
                    atacado_d   = acao_alvo;
                    aceita_d    = 1'b1;
                    rejeitada_d = 1'b0;
                  end
                end
                PapelMedico: begin
                  protegido_d = acao_alvo;
                  aceita_d    = 1'b1;
                  rejeitada_d = 1'b0;
                end
`ifdef VIDENTE_EN
                PapelVidente: begin
                  aceita_d     = 1'b1;
                  rejeitada_d  = 1'b0;
                  rev_valido_d = (acao_alvo != Skip);
                  rev_lobo_d   = (acao_alvo != Skip) && alvo_lobo;
                end
`endif
                default: ;
              endcase
            end
          end
        end

        StResolve: begin
          if ((atacado_q != Skip) && (atacado_q != protegido_q)) begin
            vivos_d       = vivos_q & ~mascara(atacado_q);
            eliminado_d   = atacado_q;
            elim_valido_d = 1'b1;
          end
          atacado_d   = Skip;
          protegido_d = Skip;
          fase_dia_d  = 1'b0;
          state_d     = StCheca;
        end

        StDia: begin
          if (fim_votacao) begin
            rejeitada_d = voto_valido;
            cand_d      = '0;
            max_d       = '0;
            max_cand_d  = '0;
            empate_d    = 1'b0;
            state_d     = StApura;
          end else if (voto_valido) begin
            if (eleitor_vivo && voto_ok) begin
              for (int i = 0; i < N_JOG; i++) begin
                if (IDW'(i) == voto_eleitor) votos_d[i] = voto_alvo;
              end
              aceita_d = 1'b1;
            end else begin
              rejeitada_d = 1'b1;
            end
          end
        end

        StApura: begin
          if (cand_q == IDW'(N_JOG)) begin
            // Scan finished: unique strict maximum above zero is eliminated.
            if ((max_q != '0) && !empate_q) begin
              vivos_d       = vivos_q & ~mascara(max_cand_q);
              eliminado_d   = max_cand_q;
              elim_valido_d = 1'b1;
            end
            votos_d    = '1;
            fase_dia_d = 1'b1;
            state_d    = StCheca;
          end else begin
            if (contagem > max_q) begin
              max_d      = contagem;
              max_cand_d = cand_q;
              empate_d   = 1'b0;
            end else if ((contagem == max_q) && (contagem != '0)) begin
              empate_d = 1'b1;
            end
            cand_d = cand_q + IDW'(1);
          end
        end

        StCheca: begin
          if (n_lobos_c == '0) begin
            aldeia_d = 1'b1;
            state_d  = StFim;
          end else if (n_lobos_c >= (n_vivos_c - n_lobos_c)) begin
            lobo_d  = 1'b1;
            state_d = StFim;
          end else begin
            state_d = fase_dia_q ? StNoite : StDia;
          end
        end

        StIdle, StFim: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock or negedge rst_global_n) begin
    if (!rst_global_n) begin
      state_q       <= StIdle;
      vivos_q       <= '0;
      papeis_q      <= '0;
      atacado_q     <= Skip;
      protegido_q   <= Skip;
      votos_q       <= '1;
      fase_dia_q    <= 1'b0;
      cand_q        <= '0;
      max_q         <= '0;
      max_cand_q    <= '0;
      empate_q      <= 1'b0;
      aceita_q      <= 1'b0;
      rejeitada_q   <= 1'b0;
      eliminado_q   <= '0;
      elim_valido_q <= 1'b0;
      lobo_q        <= 1'b0;
      aldeia_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      vivos_q       <= vivos_d;
      papeis_q      <= papeis_d;
      atacado_q     <= atacado_d;
      protegido_q   <= protegido_d;
      votos_q       <= votos_d;
      fase_dia_q    <= fase_dia_d;
      cand_q        <= cand_d;
      max_q         <= max_d;
      max_cand_q    <= max_cand_d;
      empate_q      <= empate_d;
      aceita_q      <= aceita_d;
      rejeitada_q   <= rejeitada_d;
      eliminado_q   <= eliminado_d;
      elim_valido_q <= elim_valido_d;
      lobo_q        <= lobo_d;
      aldeia_q      <= aldeia_d;
    end
  end

`ifdef VIDENTE_EN
  always_ff @(posedge clock or negedge rst_global_n) begin
    if (!rst_global_n) begin
      rev_lobo_q   <= 1'b0;
      rev_valido_q <= 1'b0;
    end else begin
      rev_lobo_q   <= rev_lobo_d;
      rev_valido_q <= rev_valido_d;
    end
  end

  assign revelado_lobo   = rev_lobo_q;
  assign revelado_valido = rev_valido_q;
`else
  assign revelado_lobo   = 1'b0;
  assign revelado_valido = 1'b0;
`endif

  assign vivos            = vivos_q;
  assign n_vivos          = n_vivos_c;
  assign n_lobos_vivos    = n_lobos_c;
  assign acao_aceita      = aceita_q;
  assign acao_rejeitada   = rejeitada_q;
  assign eliminado        = eliminado_q;
  assign eliminado_valido = elim_valido_q;
  assign lobo_ganhou      = lobo_q;
  assign aldeia_ganhou    = aldeia_q;
  assign estado           = state_q;

endmodule

// File: tb/tb_motor_rodada.sv
// Directed bench for motor_rodada (N_JOG=8, IDW=4). Inputs change and outputs are sampled 1 time
// unit after each rising edge.
module tb_motor_rodada;
  localparam int unsigned N = 8;
  localparam int unsigned W = 4;

  logic           clock = 1'b0;
  logic           rst_global_n = 1'b0;
  logic           novo_jogo = 1'b0;
  logic [2*N-1:0] papeis = '0;
  logic           acao_valida = 1'b0;
  logic [W-1:0]   acao_jogador = '0;
  logic [W-1:0]   acao_alvo = '0;
  logic           fim_noite = 1'b0;
  logic           voto_valido = 1'b0;
  logic [W-1:0]   voto_eleitor = '0;
  logic [W-1:0]   voto_alvo = '0;
  logic           fim_votacao = 1'b0;
  logic [N-1:0]   vivos;
  logic [W-1:0]   n_vivos, n_lobos_vivos, eliminado;
  logic           acao_aceita, acao_rejeitada, eliminado_valido;
  logic           lobo_ganhou, aldeia_ganhou, revelado_lobo, revelado_valido;
  logic [2:0]     estado;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  motor_rodada #(.N_JOG(N), .IDW(W)) dut (
    .clock            (clock),
    .rst_global_n     (rst_global_n),
    .novo_jogo        (novo_jogo),
    .papeis           (papeis),
    .acao_valida      (acao_valida),
    .acao_jogador     (acao_jogador),
    .acao_alvo        (acao_alvo),
    .fim_noite        (fim_noite),
    .voto_valido      (voto_valido),
    .voto_eleitor     (voto_eleitor),
    .voto_alvo        (voto_alvo),
    .fim_votacao      (fim_votacao),
    .vivos            (vivos),
    .n_vivos          (n_vivos),
    .n_lobos_vivos    (n_lobos_vivos),
    .acao_aceita      (acao_aceita),
    .acao_rejeitada   (acao_rejeitada),
    .eliminado        (eliminado),
    .eliminado_valido (eliminado_valido),
    .lobo_ganhou      (lobo_ganhou),
    .aldeia_ganhou    (aldeia_ganhou),
    .estado           (estado),
    .revelado_lobo    (revelado_lobo),
    .revelado_valido  (revelado_valido)
  );

  task automatic passo();
    @(posedge clock);
    #1;
  endtask

  task automatic inicia(input logic [2*N-1:0] p);
    novo_jogo = 1'b1;
    papeis    = p;
    passo();
    novo_jogo = 1'b0;
  endtask

  task automatic acao(input logic [W-1:0] ator, input logic [W-1:0] alvo);
    acao_valida  = 1'b1;
    acao_jogador = ator;
    acao_alvo    = alvo;
    passo();
    acao_valida  = 1'b0;
  endtask

  task automatic voto(input logic [W-1:0] eleitor, input logic [W-1:0] alvo);
    voto_valido  = 1'b1;
    voto_eleitor = eleitor;
    voto_alvo    = alvo;
    passo();
    voto_valido  = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (estado !== 3'd0) begin n_err++; $display("FAIL rst_estado got %0d want 0", estado); end
    n_cmp++; if (vivos !== 8'h00) begin n_err++; $display("FAIL rst_vivos got %h want 00", vivos); end
    n_cmp++; if (n_vivos !== 4'd0) begin n_err++; $display("FAIL rst_n_vivos got %0d want 0", n_vivos); end
    n_cmp++; if ({acao_aceita, acao_rejeitada, eliminado_valido, lobo_ganhou, aldeia_ganhou,
                 revelado_valido, eliminado} !== 10'b0) begin
      n_err++; $display("FAIL rst_pulses got nonzero pulse/flag/eliminado want 0");
    end
    rst_global_n = 1'b1;
    passo();
    // Wolves 1,4; doctor 2; seer 6; the rest villagers.
    inicia(16'h3124);
    n_cmp++; if (vivos !== 8'hFF) begin n_err++; $display("FAIL start_vivos got %h want FF", vivos); end
    n_cmp++; if (estado !== 3'd1) begin n_err++; $display("FAIL start_estado got %0d want 1", estado); end
    n_cmp++; if (n_lobos_vivos !== 4'd2) begin
      n_err++; $display("FAIL start_lobos got %0d want 2", n_lobos_vivos);
    end
  endtask

  task automatic test_noite_multi_lobo();
    acao(4'd1, 4'd3);
    n_cmp++; if (acao_aceita !== 1'b1) begin n_err++; $display("FAIL n1_w1 got %b want 1", acao_aceita); end
    acao(4'd4, 4'd5);
    n_cmp++; if (acao_aceita !== 1'b1) begin n_err++; $display("FAIL n1_w4 got %b want 1", acao_aceita); end
    acao(4'd2, 4'd3);
    n_cmp++; if (acao_aceita !== 1'b1) begin n_err++; $display("FAIL n1_doc got %b want 1", acao_aceita); end
    fim_noite = 1'b1; passo(); fim_noite = 1'b0;
    n_cmp++; if (estado !== 3'd2) begin n_err++; $display("FAIL n1_resolve got %0d want 2", estado); end
    passo();
    n_cmp++; if ({eliminado_valido, eliminado} !== 5'h15) begin
      n_err++; $display("FAIL n1_elim got %b/%0d want 1/5", eliminado_valido, eliminado);
    end
    n_cmp++; if (vivos !== 8'hDF) begin n_err++; $display("FAIL n1_vivos got %h want DF", vivos); end
    passo();
    n_cmp++; if (estado !== 3'd3) begin n_err++; $display("FAIL n1_to_dia got %0d want 3", estado); end
  endtask

  task automatic test_votacao_empate();
    int rej = 0;
    int pulsos = 0;
    voto(4'd5, 4'd3); rej += int'(acao_rejeitada);
    voto(4'd0, 4'd5); rej += int'(acao_rejeitada);
    voto(4'd0, 4'd9); rej += int'(acao_rejeitada);
    n_cmp++; if (rej !== 3) begin n_err++; $display("FAIL d1_rej got %0d want 3", rej); end
    acao(4'd1, 4'd0);
    n_cmp++; if ({acao_aceita, acao_rejeitada} !== 2'b00) begin
      n_err++; $display("FAIL d1_acao_ignored got %b want 00", {acao_aceita, acao_rejeitada});
    end
    voto(4'd0, 4'd3); voto(4'd1, 4'd3); voto(4'd2, 4'd7); voto(4'd3, 4'd7);
    n_cmp++; if (acao_aceita !== 1'b1) begin n_err++; $display("FAIL d1_voto got %b want 1", acao_aceita); end
    fim_votacao = 1'b1; passo(); fim_votacao = 1'b0;
    for (int j = 0; j <= N; j++) begin
      passo();
      pulsos += int'(eliminado_valido);
    end
    n_cmp++; if (pulsos !== 0) begin n_err++; $display("FAIL d1_tie_elim got %0d want 0", pulsos); end
    n_cmp++; if (estado !== 3'd5) begin n_err++; $display("FAIL d1_checa got %0d want 5", estado); end
    passo();
    n_cmp++; if (estado !== 3'd1) begin n_err++; $display("FAIL d1_to_noite got %0d want 1", estado); end
  endtask

  task automatic test_acoes_invalidas();
    int rej = 0;
    acao(4'd1, 4'd7);
    n_cmp++; if (acao_aceita !== 1'b1) begin n_err++; $display("FAIL n2_w1 got %b want 1", acao_aceita); end
    acao(4'd1, 4'd4); rej += int'(acao_rejeitada);
    acao(4'd1, 4'd5); rej += int'(acao_rejeitada);
    acao(4'd1, 4'd9); rej += int'(acao_rejeitada);
    n_cmp++; if (rej !== 3) begin n_err++; $display("FAIL n2_rej got %0d want 3", rej); end
    acao(4'd2, 4'd0);
    voto(4'd0, 4'd3);
    n_cmp++; if ({acao_aceita, acao_rejeitada} !== 2'b00) begin
      n_err++; $display("FAIL n2_voto_ignored got %b want 00", {acao_aceita, acao_rejeitada});
    end
    fim_noite = 1'b1; passo(); fim_noite = 1'b0;
    passo();
    n_cmp++; if ({eliminado_valido, eliminado} !== 5'h17) begin
      n_err++; $display("FAIL n2_elim got %b/%0d want 1/7", eliminado_valido, eliminado);
    end
    passo();
    n_cmp++; if (vivos !== 8'h5F) begin n_err++; $display("FAIL n2_vivos got %h want 5F", vivos); end
    n_cmp++; if (estado !== 3'd3) begin n_err++; $display("FAIL n2_to_dia got %0d want 3", estado); end
  endtask

  task automatic test_revoto();
    int pulsos = 0;
    voto(4'd0, 4'd3); voto(4'd1, 4'd3); voto(4'd2, 4'd0); voto(4'd3, 4'd0);
    voto(4'd2, 4'd3);
    n_cmp++; if (acao_aceita !== 1'b1) begin n_err++; $display("FAIL d2_revoto got %b want 1", acao_aceita); end
    fim_votacao = 1'b1; voto_valido = 1'b1; voto_eleitor = 4'd3; voto_alvo = 4'd3;
    passo();
    fim_votacao = 1'b0; voto_valido = 1'b0;
    n_cmp++; if ({acao_rejeitada, estado} !== 4'b1100) begin
      n_err++; $display("FAIL d2_close_drop got %b/%0d want 1/4", acao_rejeitada, estado);
    end
    for (int j = 0; j < N; j++) begin
      passo();
      pulsos += int'(eliminado_valido);
    end
    n_cmp++; if (pulsos !== 0) begin n_err++; $display("FAIL d2_early_elim got %0d want 0", pulsos); end
    passo();
    n_cmp++; if ({eliminado_valido, eliminado} !== 5'h13) begin
      n_err++; $display("FAIL d2_elim got %b/%0d want 1/3", eliminado_valido, eliminado);
    end
    n_cmp++; if (vivos !== 8'h57) begin n_err++; $display("FAIL d2_vivos got %h want 57", vivos); end
    passo();
    n_cmp++; if (estado !== 3'd1) begin n_err++; $display("FAIL d2_to_noite got %0d want 1", estado); end
  endtask

  task automatic test_vidente_lobo_ganha();
    acao(4'd6, 4'd4);
`ifdef VIDENTE_EN
    n_cmp++; if ({acao_aceita, revelado_valido, revelado_lobo} !== 3'b111) begin
      n_err++; $display("FAIL seer got %b want 111", {acao_aceita, revelado_valido, revelado_lobo});
    end
`else
    n_cmp++; if ({acao_rejeitada, revelado_valido, revelado_lobo} !== 3'b100) begin
      n_err++; $display("FAIL seer_off got %b want 100", {acao_rejeitada, revelado_valido, revelado_lobo});
    end
`endif
    acao(4'd1, 4'd0);
    acao_valida = 1'b1; acao_jogador = 4'd4; acao_alvo = 4'd2; fim_noite = 1'b1;
    passo();
    acao_valida = 1'b0; fim_noite = 1'b0;
    n_cmp++; if ({acao_rejeitada, estado} !== 4'b1010) begin
      n_err++; $display("FAIL n3_close_drop got %b/%0d want 1/2", acao_rejeitada, estado);
    end
    passo();
    n_cmp++; if ({eliminado_valido, eliminado, vivos} !== {1'b1, 4'd0, 8'h56}) begin
      n_err++; $display("FAIL n3_elim got %b/%0d/%h want 1/0/56", eliminado_valido, eliminado, vivos);
    end
    passo();
    n_cmp++; if ({lobo_ganhou, aldeia_ganhou, estado} !== 5'b10110) begin
      n_err++; $display("FAIL lobo_win got %b/%b/%0d want 1/0/6", lobo_ganhou, aldeia_ganhou, estado);
    end
    acao(4'd1, 4'd2);
    n_cmp++; if ({acao_aceita, acao_rejeitada} !== 2'b00) begin
      n_err++; $display("FAIL fim_ignore got %b want 00", {acao_aceita, acao_rejeitada});
    end
    fim_noite = 1'b1; passo(); fim_noite = 1'b0;
    passo();
    n_cmp++; if ({estado, lobo_ganhou, vivos} !== {3'd6, 1'b1, 8'h56}) begin
      n_err++; $display("FAIL fim_hold got %0d/%b/%h want 6/1/56", estado, lobo_ganhou, vivos);
    end
  endtask

  task automatic test_aldeia_ganha();
    // Wolf 0, doctor 5.
    inicia(16'h0801);
    n_cmp++; if ({lobo_ganhou, estado, n_lobos_vivos} !== {1'b0, 3'd1, 4'd1}) begin
      n_err++; $display("FAIL g2_start got %b/%0d/%0d want 0/1/1", lobo_ganhou, estado, n_lobos_vivos);
    end
    acao(4'd3, 4'd0);
    n_cmp++; if (acao_rejeitada !== 1'b1) begin
      n_err++; $display("FAIL g2_villager got %b want 1", acao_rejeitada);
    end
    acao(4'd0, 4'd3); acao(4'd5, 4'd3);
    fim_noite = 1'b1; passo(); fim_noite = 1'b0;
    passo();
    n_cmp++; if ({eliminado_valido, vivos} !== 9'h0FF) begin
      n_err++; $display("FAIL g2_saved got %b/%h want 0/FF", eliminado_valido, vivos);
    end
    passo();
    voto(4'd1, 4'd0); voto(4'd2, 4'd0); voto(4'd3, 4'd0); voto(4'd0, 4'd1);
    fim_votacao = 1'b1; passo(); fim_votacao = 1'b0;
    for (int j = 0; j <= N; j++) passo();
    n_cmp++; if ({eliminado_valido, eliminado, vivos} !== {1'b1, 4'd0, 8'hFE}) begin
      n_err++; $display("FAIL g2_elim got %b/%0d/%h want 1/0/FE", eliminado_valido, eliminado, vivos);
    end
    passo();
    n_cmp++; if ({aldeia_ganhou, lobo_ganhou, estado} !== 5'b10110) begin
      n_err++; $display("FAIL aldeia_win got %b/%b/%0d want 1/0/6", aldeia_ganhou, lobo_ganhou, estado);
    end
  endtask

  task automatic test_reset_apura();
    inicia(16'h0801);
    fim_noite = 1'b1; passo(); fim_noite = 1'b0;
    passo(); passo();
    fim_votacao = 1'b1; passo(); fim_votacao = 1'b0;
    passo(); passo();
    n_cmp++; if (estado !== 3'd4) begin n_err++; $display("FAIL pre_rst_apura got %0d want 4", estado); end
    rst_global_n = 1'b0;
    #1;
    n_cmp++; if ({estado, vivos, n_vivos} !== 15'd0) begin
      n_err++; $display("FAIL rst_apura got %0d/%h/%0d want 0/00/0", estado, vivos, n_vivos);
    end
    n_cmp++; if ({acao_aceita, acao_rejeitada, eliminado_valido, aldeia_ganhou} !== 4'b0) begin
      n_err++; $display("FAIL rst_apura_pulses got nonzero want 0");
    end
    #2 rst_global_n = 1'b1;
    passo();
    inicia(16'h0801);
    n_cmp++; if ({vivos, estado} !== {8'hFF, 3'd1}) begin
      n_err++; $display("FAIL restart got %h/%0d want FF/1", vivos, estado);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_noite_multi_lobo();
    test_votacao_empate();
    test_acoes_invalidas();
    test_revoto();
    test_vidente_lobo_ganha();
    test_aldeia_ganha();
    test_reset_apura();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
